// File: rtl/encoder_pkg.sv
// Shared definitions for the quadrature encoder emulator and reader.
//   dir_t       : direction codes (DIR_NONE, DIR_CW, DIR_CCW)
//   enc_state_t : IDLE/RUN state encoding
//   gray_step   : next (A,B) phase for a single clockwise or counter-clockwise step
package encoder_pkg;

   typedef enum logic [1:0] {
      DIR_NONE = 2'b00,
      DIR_CW   = 2'b01,
      DIR_CCW  = 2'b10
   } dir_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } enc_state_t;

   // Clockwise order of {A,B}: 00 -> 10 -> 11 -> 01 -> 00; counter-clockwise is the reverse.
   function automatic logic [1:0] gray_step(input logic [1:0] ab, input logic cw);
      logic [1:0] nxt;
      nxt = 2'b00;
      if (cw) begin
         case (ab)
            2'b00:   nxt = 2'b10;
            2'b10:   nxt = 2'b11;
            2'b11:   nxt = 2'b01;
            default: nxt = 2'b00;
         endcase
      end else begin
         case (ab)
            2'b00:   nxt = 2'b01;
            2'b01:   nxt = 2'b11;
            2'b11:   nxt = 2'b10;
            default: nxt = 2'b00;
         endcase
      end
      return nxt;
   endfunction

   function automatic logic dir_is_motion(input logic [1:0] dir);
      return (dir == DIR_CW) || (dir == DIR_CCW);
   endfunction

endpackage

// File: rtl/encoder_tick_gen.sv
// Step-rate divider: counts 0..DIV-1 while enabled and flags the terminal count.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of the count (priority over en)
//   en       : count enable
//   tick     : high for the one cycle in which the count sits at DIV-1 with en high
module encoder_tick_gen #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/encoder_emulator.sv
// Quadrature encoder emulator: emits cmd_count Gray-coded (A,B) steps in the
// commanded direction, one step every STEP_DIV clocks, and tracks a signed position.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   cmd_valid      : command request, accepted when cmd_ready is high
//   cmd_dir        : 01 clockwise, 10 counter-clockwise, 00/11 no motion
//   cmd_count      : number of quarter-steps to emit
//   cmd_ready      : high while IDLE
//   A, B           : registered quadrature outputs
//   done           : one-cycle pulse on command completion (or on a no-motion command)
//   position       : signed running step count, wraps modulo 2^16
//   Z              : index pulse
// Configuration macro: ENCODER_INDEX_EN enables the index counter (0..PPR-1) driving Z;
// without it Z is tied low.
module encoder_emulator
   import encoder_pkg::*;
#(
   parameter int unsigned STEP_DIV = 4,
   parameter int unsigned PPR      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   input  logic [1:0]         cmd_dir,
   input  logic [7:0]         cmd_count,
   output logic               cmd_ready,
   output logic               A,
   output logic               B,
   output logic               done,
   output logic signed [15:0] position,
   output logic               Z
);

   if (STEP_DIV < 2 || STEP_DIV > 65535 || PPR < 1) begin : g_bad_param
      $error("encoder_emulator: STEP_DIV must be 2..65535 and PPR at least 1");
   end

   enc_state_t         state_q, state_d;
   dir_t               dir_q, dir_d;
   logic [7:0]         rem_q, rem_d;
   logic [1:0]         ab_q, ab_d;
   logic signed [15:0] pos_q, pos_d;
   logic               done_q, done_d;
   logic               accept;
   logic               tick;

   encoder_tick_gen #(
      .DIV (STEP_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (state_q == ST_RUN),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_NONE;
         rem_q   <= '0;
         ab_q    <= '0;
         pos_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         rem_q   <= rem_d;
         ab_q    <= ab_d;
         pos_q   <= pos_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      rem_d   = rem_q;
      ab_d    = ab_q;
      pos_d   = pos_q;
      done_d  = 1'b0;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               accept = 1'b1;
               if (dir_is_motion(cmd_dir) && (cmd_count != 8'd0)) begin
                  state_d = ST_RUN;
                  dir_d   = dir_t'(cmd_dir);
                  rem_d   = cmd_count;
               end else begin
                  // No-motion command completes immediately.
                  done_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (tick) begin
               ab_d  = gray_step(ab_q, dir_q == DIR_CW);
               pos_d = (dir_q == DIR_CW) ? pos_q + 16'sd1 : pos_q - 16'sd1;
               rem_d = rem_q - 8'd1;
               if (rem_q == 8'd1) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign A         = ab_q[1];
   assign B         = ab_q[0];
   assign done      = done_q;
   assign position  = pos_q;

`ifdef ENCODER_INDEX_EN
   localparam int unsigned IDX_W = (PPR > 1) ? $clog2(PPR) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PPR - 1);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic             z_q;

   always_comb begin
      idx_d = idx_q;
      if ((state_q == ST_RUN) && tick) begin
         if (dir_q == DIR_CW) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         end else begin
            idx_d = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
         end
      end
   end

   // Z is registered from the next index so it tracks idx_q yet stays low during reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         z_q   <= 1'b0;
      end else begin
         idx_q <= idx_d;
         z_q   <= (idx_d == '0);
      end
   end

   assign Z = z_q;
`else
   assign Z = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_emulator.sv
// Directed self-checking bench for encoder_emulator (STEP_DIV=4, PPR=16).
module tb_encoder_emulator;

   logic               clk;
   logic               rst;
   logic               cmd_valid;
   logic [1:0]         cmd_dir;
   logic [7:0]         cmd_count;
   logic               cmd_ready;
   logic               A;
   logic               B;
   logic               done;
   logic signed [15:0] position;
   logic               Z;

   int n_assert = 0;
   int n_fail   = 0;

   // Reader-style monitor tallies
   int         cw_steps  = 0;
   int         ccw_steps = 0;
   int         illegal   = 0;
   logic [1:0] prev_ab   = 2'b00;

   encoder_emulator #(
      .STEP_DIV (4),
      .PPR      (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_dir   (cmd_dir),
      .cmd_count (cmd_count),
      .cmd_ready (cmd_ready),
      .A         (A),
      .B         (B),
      .done      (done),
      .position  (position),
      .Z         (Z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] reader_cw_of(input logic [1:0] ab);
      case (ab)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst && ({A, B} != prev_ab)) begin
         if ({A, B} == reader_cw_of(prev_ab))      cw_steps++;
         else if (prev_ab == reader_cw_of({A, B})) ccw_steps++;
         else                                      illegal++;
      end
      prev_ab = {A, B};
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue a moving command and check every cycle until completion. cmd_valid is
   // held high with conflicting values during RUN, which must be ignored.
   task automatic run_cmd(input logic [1:0] dir, input int cnt, input logic [1:0] ab0,
                          input logic [1:0] exp_ab [10], input logic [15:0] exp_pos);
      logic [1:0] cur;
      cur = ab0;
      @(negedge clk);
      check("ready_idle", 16'(cmd_ready), 16'd1);
      cmd_valid = 1'b1;
      cmd_dir   = dir;
      cmd_count = 8'(cnt);
      @(negedge clk);
      check("ready_run", 16'(cmd_ready), 16'd0);
      cmd_dir   = (dir == 2'b01) ? 2'b10 : 2'b01;
      cmd_count = 8'd7;
      for (int s = 0; s < cnt; s++) begin
         for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) cur = exp_ab[s];
            check("ab", 16'({A, B}), 16'(cur));
            check("done", 16'(done), 16'((s == cnt - 1) && (k == 4)));
         end
      end
      cmd_valid = 1'b0;
      cmd_dir   = 2'b00;
      cmd_count = 8'd0;
      check("ready_end", 16'(cmd_ready), 16'd1);
      check("pos_end", position, exp_pos);
      @(negedge clk);
      check("done_clear", 16'(done), 16'd0);
      check("ab_hold", 16'({A, B}), 16'(cur));
   endtask

   // No-motion command: done one cycle after acceptance, nothing else moves.
   task automatic reject_cmd(input logic [1:0] dir, input logic [7:0] cnt,
                             input logic [1:0] ab, input logic [15:0] pos);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_dir   = dir;
      cmd_count = cnt;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("rej_done", 16'(done), 16'd1);
      check("rej_ready", 16'(cmd_ready), 16'd1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rej_done_off", 16'(done), 16'd0);
         check("rej_ab", 16'({A, B}), 16'(ab));
      end
      check("rej_pos", position, pos);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      logic       exp_z;
      logic [15:0] pnow;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_dir   = 2'b00;
      cmd_count = 8'd0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ab", 16'({A, B}), 16'd0);
      check("rst_done", 16'(done), 16'd0);
      check("rst_z", 16'(Z), 16'd0);
      check("rst_pos", position, 16'd0);
      check("rst_ready", 16'(cmd_ready), 16'd1);
      #2 rst = 1'b0;

      // CW x4 from reset: 10, 11, 01, 00, position 4
      run_cmd(2'b01, 4, 2'b00, '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}, 16'd4);

      // CCW x5 from 00 / position 0: 01, 11, 10, 00, 01, position -5
      pulse_reset();
      run_cmd(2'b10, 5, 2'b00, '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}, 16'hFFFB);

      // No-motion commands
      reject_cmd(2'b01, 8'd0, 2'b01, 16'hFFFB);
      reject_cmd(2'b11, 8'd5, 2'b01, 16'hFFFB);
      reject_cmd(2'b00, 8'd3, 2'b01, 16'hFFFB);

      // Phase continuity: CW x2 from 01 -> 00, 10, position -3
      run_cmd(2'b01, 2, 2'b01, '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}, 16'hFFFD);

      // Reset mid-run abort of a 10-step CW command
      pulse_reset();
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_dir   = 2'b01;
      cmd_count = 8'd10;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_pre_ab", 16'({A, B}), 16'b10);
      check("abort_pre_pos", position, 16'd1);
      #2 rst = 1'b1;
      #1;
      check("abort_ab", 16'({A, B}), 16'd0);
      check("abort_pos", position, 16'd0);
      check("abort_done", 16'(done), 16'd0);
      check("abort_ready", 16'(cmd_ready), 16'd1);
      @(negedge clk);
      #2 rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         check("abort_no_done", 16'(done), 16'd0);
         check("abort_ab_hold", 16'({A, B}), 16'd0);
      end
      check("abort_ready_after", 16'(cmd_ready), 16'd1);

      // CW x32: index pulse at positions 0, 16, 32 when the index feature is built in
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_dir   = 2'b01;
      cmd_count = 8'd32;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int s = 0; s < 32; s++) begin
         for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            pnow = 16'(s + ((k == 4) ? 1 : 0));
`ifdef ENCODER_INDEX_EN
            exp_z = (pnow[3:0] == 4'd0);
`else
            exp_z = 1'b0;
`endif
            check("z", 16'(Z), 16'(exp_z));
         end
      end
      check("idx_pos", position, 16'd32);
      check("idx_done", 16'(done), 16'd1);
      @(negedge clk);

      // Reader view of every transition seen outside reset
      check("reader_cw", 16'(cw_steps), 16'd39);
      check("reader_ccw", 16'(ccw_steps), 16'd5);
      check("reader_illegal", 16'(illegal), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
